dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/combi_pkg.sv | 28 ++
 rtl/dmem_lane.sv | 48 ++++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/combi_pkg.sv
// Shared types for the data-memory responder: access-size encodings, FSM states
// and the alignment rule used when misaligned-access faulting is compiled in.
package combi_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            default:   return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane enables, store-data replication and load extraction/extension for
// one 32-bit little-endian memory word.
module dmem_lane
    import combi_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  offset_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Half accesses look only at offset bit 1 and words ignore the offset, so a
    // misaligned address falls to its natural alignment without extra logic.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
        lane8   = '0;
        lane16  = '0;
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                lane8   = 8'(rword_i >> {offset_i, 3'b000});
                rdata_o = {{24{signed_i & lane8[7]}}, lane8};
            end
            SIZE_HALF: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                lane16  = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
                rdata_o = {{16{signed_i & lane16[15]}}, lane16};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states.
// Optional macro DMEM_MISALIGN_ERR_EN faults misaligned half/word accesses.
module dmem_responder
    import combi_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] ReadData,
    output logic        resp_err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]             addr_q, wdata_q;
    logic                    write_q, signed_q;
    mem_size_e               size_q;
    logic [31:0]             rdata_q, rdata_d;

    logic [31:0]             mem [DEPTH_WORDS];

    logic                    accept, do_access, fault;
    logic [31:0]             acc_addr, acc_wdata;
    logic                    acc_write, acc_signed;
    mem_size_e               acc_size;
    logic [IDX_W-1:0]        acc_idx;
    logic [3:0]              lane_be;
    logic [31:0]             lane_wdata, lane_rdata;
    logic                    unused_addr_hi;

    // With no wait states the access happens on the accept edge itself, so it
    // must use the live request rather than the latched copy.
    assign acc_addr   = ZERO_WAIT ? DataAddr            : addr_q;
    assign acc_wdata  = ZERO_WAIT ? WriteData           : wdata_q;
    assign acc_write  = ZERO_WAIT ? MemWrite            : write_q;
    assign acc_signed = ZERO_WAIT ? MemSigned           : signed_q;
    assign acc_size   = ZERO_WAIT ? mem_size_e'(MemSize) : size_q;
    assign acc_idx    = acc_addr[IDX_W+1:2];
    assign unused_addr_hi = ^acc_addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign fault = is_misaligned(acc_size, acc_addr[1:0]);
`else
    assign fault = 1'b0;
`endif

    dmem_lane u_lane (
        .size_i   (acc_size),
        .offset_i (acc_addr[1:0]),
        .signed_i (acc_signed),
        .wdata_i  (acc_wdata),
        .rword_i  (mem[acc_idx]),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (do_access) rdata_d = (acc_write || fault) ? '0 : lane_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q   <= DataAddr;
                wdata_q  <= WriteData;
                write_q  <= MemWrite;
                size_q   <= mem_size_e'(MemSize);
                signed_q <= MemSigned;
            end
        end
    end

    // Array is deliberately not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && do_access && acc_write && !fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_be[i]) mem[acc_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst)           err_q <= 1'b0;
        else if (do_access) err_q <= fault;
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign ReadData   = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-array reference model with
// per-cycle output comparison, plus literal expectations for key accesses.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] DataAddr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'b10;
    logic        MemSigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] ReadData;
    logic        resp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .DataAddr   (DataAddr),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .ReadData   (ReadData),
        .resp_err   (resp_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0] mb [DEPTH*4];

    function automatic void mdl_apply(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] wd, input logic sg,
                                      output logic [31:0] rd, output logic er);
        int unsigned n, base;
        logic [31:0] v;
        n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        rd = '0;
        er = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        if ((a % n) != 0) begin
            er = 1'b1;
            return;
        end
`endif
        base = ((a / 4) % DEPTH) * 4 + (((a % 4) / n) * n);
        if (we) begin
            for (int k = 0; k < int'(n); k++) mb[base + k] = wd[8*k +: 8];
        end else begin
            v = '0;
            for (int k = 0; k < int'(n); k++) v[8*k +: 8] = mb[base + k];
            if (sg && n < 4 && v[8*n-1]) begin
                for (int k = int'(n); k < 4; k++) v[8*k +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    logic        m_live = 1'b0, m_busy = 1'b0, m_resp = 1'b0;
    int          m_edge = 0, m_due = 0;
    logic        o_we, o_sg;
    logic [1:0]  o_sz;
    logic [31:0] o_a, o_wd;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    always @(posedge clk) begin
        logic [31:0] r;
        logic        e;
        m_edge <= m_edge + 1;
        if (!rst) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
            m_resp <= 1'b0;
        end else if (m_resp) begin
            if (resp_ready) m_resp <= 1'b0;
        end else if (m_busy) begin
            if (m_edge == m_due) begin
                mdl_apply(o_we, o_sz, o_a, o_wd, o_sg, r, e);
                m_rdata <= r;
                m_err   <= e;
                m_busy  <= 1'b0;
                m_resp  <= 1'b1;
            end
        end else if (req_valid) begin
            if (WAITC == 0) begin
                mdl_apply(MemWrite, MemSize, DataAddr, WriteData, MemSigned, r, e);
                m_rdata <= r;
                m_err   <= e;
                m_resp  <= 1'b1;
            end else begin
                o_we   <= MemWrite;
                o_sz   <= MemSize;
                o_a    <= DataAddr;
                o_wd   <= WriteData;
                o_sg   <= MemSigned;
                m_busy <= 1'b1;
                m_due  <= m_edge + int'(WAITC);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("req_ready", 32'(req_ready), 32'(!(m_busy || m_resp)));
            check("resp_valid", 32'(resp_valid), 32'(m_resp));
            if (m_resp) begin
                check("ReadData", ReadData, m_rdata);
                check("resp_err", 32'(resp_err), 32'(m_err));
            end
        end
    end

    task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic sg,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; MemWrite = we; MemSize = sz; DataAddr = a;
        WriteData = wd; MemSigned = sg; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
        rd = ReadData;
        er = resp_err;
        @(posedge clk);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd; logic er; int lat;
        access(1'b1, sz, a, wd, 1'b0, rd, er, lat);
    endtask

    task automatic ld(input string name, input logic [1:0] sz, input logic [31:0] a,
                      input logic sg, input logic [31:0] exp);
        logic [31:0] rd; logic er; int lat;
        access(1'b0, sz, a, 32'h0, sg, rd, er, lat);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd, held;
        logic        er;
        int          lat, guard;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_ReadData", ReadData, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b1;

        st(2'b10, 32'h20, 32'hCAFEF00D);
        st(2'b10, 32'h10, 32'hDEADBEEF);
        access(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, rd, er, lat);
        check("ld_w_10", rd, 32'hDEADBEEF);
        check("latency", 32'(lat), 32'd3);

        st(2'b00, 32'h11, 32'h00000080);
        ld("ld_bs_11", 2'b00, 32'h11, 1'b1, 32'hFFFFFF80);
        ld("ld_bu_11", 2'b00, 32'h11, 1'b0, 32'h00000080);
        ld("ld_w_after_b", 2'b10, 32'h10, 1'b0, 32'hDEAD80EF);
        ld("ld_hu_12", 2'b01, 32'h12, 1'b0, 32'h0000DEAD);
        ld("ld_hs_12", 2'b01, 32'h12, 1'b1, 32'hFFFFDEAD);
        ld("ld_hs_10", 2'b01, 32'h10, 1'b1, 32'hFFFF80EF);
        ld("ld_sz11_10", 2'b11, 32'h10, 1'b1, 32'hDEAD80EF);

        st(2'b01, 32'h16, 32'hFFFF1234);
        ld("ld_hu_16", 2'b01, 32'h16, 1'b0, 32'h00001234);
        st(2'b00, 32'h17, 32'h000000AB);
        ld("ld_hs_16", 2'b01, 32'h16, 1'b1, 32'hFFFFAB34);
        ld("ld_bu_16", 2'b00, 32'h16, 1'b0, 32'h00000034);

        // Stalled response; a competing store is held on the request side meanwhile.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; MemWrite = 1'b0; MemSize = 2'b10; DataAddr = 32'h10; MemSigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b1; WriteData = 32'hFFFFFFFF;
        guard = 0;
        while (!resp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!resp_valid) check("stall_timeout", 32'(resp_valid), 32'd1);
        held = ReadData;
        check("stall_data", held, 32'hDEAD80EF);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_hold", ReadData, held);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        ld("ld_after_stall", 2'b10, 32'h10, 1'b0, 32'hDEAD80EF);

        st(2'b10, DEPTH * 4 + 32'h10, 32'h0BADF00D);
        ld("alias_10", 2'b10, 32'h10, 1'b0, 32'h0BADF00D);

        // Reset while the store sits in its wait states.
        @(negedge clk);
        req_valid = 1'b1; MemWrite = 1'b1; MemSize = 2'b10; DataAddr = 32'h20; WriteData = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_ReadData", ReadData, 32'd0);
        check("abort_resp_err", 32'(resp_err), 32'd0);
        ld("abort_mem_20", 2'b10, 32'h20, 1'b0, 32'hCAFEF00D);

        access(1'b0, 2'b10, 32'h13, 32'h0, 1'b0, rd, er, lat);
        access(1'b1, 2'b01, 32'h11, 32'h00005555, 1'b0, held, er, guard);
`ifdef DMEM_MISALIGN_ERR_EN
        check("mis_ld_data", rd, 32'h0);
        check("mis_st_err", 32'(er), 32'd1);
        check("mis_latency", 32'(lat), 32'd3);
        ld("mis_st_nowrite", 2'b10, 32'h10, 1'b0, 32'h0BADF00D);
`else
        check("mis_ld_data", rd, 32'h0BADF00D);
        check("mis_st_err", 32'(er), 32'd0);
        check("mis_latency", 32'(lat), 32'd3);
        ld("mis_st_aligned", 2'b10, 32'h10, 1'b0, 32'h0BAD5555);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
